riscv_dmem_lsu: RTL and testbench

- Parametrised RV32 data memory that replaces the fixed 64-entry word-only memory.
- Adds byte/halfword/word loads and stores with sign/zero extension, and misalignment and illegal-size detection.
- Adds a valid/ready request port with an in-order response pipeline of configurable latency, plus a hardware zero-fill sequence after reset.
- Sits between the core's MEM stage and the word array; the array is held in registers.

---
 rtl/riscv_dmem_lsu.sv | 169 ++++++++++++++++
 tb/tb_riscv_dmem_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_lsu.sv
// RV32 data memory with byte/half/word access, valid/ready request port and an in-order
// response pipeline of READ_LAT cycles. Define RISC_DMEM_BOUNDS_CHECK_EN to flag out-of-range addresses.
module riscv_dmem_lsu #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic [31:0]      mem_q [DEPTH];

    logic [READ_LAT-1:0]       pipe_valid_q, pipe_valid_d;
    logic [READ_LAT-1:0][31:0] pipe_rdata_q, pipe_rdata_d;
    logic [READ_LAT-1:0]       pipe_err_q, pipe_err_d;

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             size_byte, size_half, size_word, is_unsigned, f3_bad;
    logic             illegal, misaligned, oob, err;
    logic [31:0]      rd_word, rd_shift, load_data;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wdata;
    logic             addr_hi_nz;

    assign req_ready = (state_q == ST_READY);
    assign init_done = (state_q == ST_READY);
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign lane      = req_addr[1:0];

    assign addr_hi_nz = |(req_addr >> (IDX_W + 2));
`ifdef RISC_DMEM_BOUNDS_CHECK_EN
    assign oob = addr_hi_nz;
`else
    logic unused_addr_hi;
    assign oob            = 1'b0;
    assign unused_addr_hi = addr_hi_nz;
`endif

    always_comb begin
        size_byte   = 1'b0;
        size_half   = 1'b0;
        size_word   = 1'b0;
        is_unsigned = 1'b0;
        f3_bad      = 1'b0;
        case (req_funct3)
            3'b000:  size_byte = 1'b1;
            3'b001:  size_half = 1'b1;
            3'b010:  size_word = 1'b1;
            3'b100:  begin size_byte = 1'b1; is_unsigned = 1'b1; end
            3'b101:  begin size_half = 1'b1; is_unsigned = 1'b1; end
            default: f3_bad = 1'b1;
        endcase
        illegal    = f3_bad | (req_we & req_funct3[2]);
        misaligned = (size_half & lane[0]) | (size_word & (|lane));
        err        = illegal | misaligned | oob;
    end

    // The word is read before this edge's write lands, so a store is visible from the next cycle on
    always_comb begin
        rd_word   = mem_q[idx];
        rd_shift  = rd_word >> {lane, 3'b000};
        load_data = rd_word;
        if (size_byte)
            load_data = is_unsigned ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        else if (size_half)
            load_data = is_unsigned ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_idx   = idx;
        mem_wdata = req_wdata;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_idx   = init_cnt_q;
            mem_wdata = 32'b0;
        end else if (accept && req_we && !err) begin
            mem_we = 1'b1;
            if (size_byte) begin
                mem_be    = 4'b0001 << lane;
                mem_wdata = {4{req_wdata[7:0]}};
            end else if (size_half) begin
                mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{req_wdata[15:0]}};
            end else begin
                mem_be = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b])
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == IDX_W'(DEPTH - 1))
                state_d = ST_READY;
        end
    end

    // Data and error stay zero in empty slots so the outputs read 0 between pulses
    always_comb begin
        pipe_valid_d    = pipe_valid_q;
        pipe_rdata_d    = pipe_rdata_q;
        pipe_err_d      = pipe_err_q;
        for (int i = READ_LAT - 1; i > 0; i--) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_rdata_d[i] = pipe_rdata_q[i-1];
            pipe_err_d[i]   = pipe_err_q[i-1];
        end
        pipe_valid_d[0] = accept;
        pipe_rdata_d[0] = (accept && !req_we && !err) ? load_data : 32'b0;
        pipe_err_d[0]   = accept && err;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            pipe_valid_q <= '0;
            pipe_rdata_q <= '0;
            pipe_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_rdata_q <= pipe_rdata_d;
            pipe_err_q   <= pipe_err_d;
        end
    end

    assign rsp_valid = pipe_valid_q[READ_LAT-1];
    assign rsp_rdata = pipe_rdata_q[READ_LAT-1];
    assign rsp_err   = pipe_err_q[READ_LAT-1];

endmodule

// File: tb/tb_riscv_dmem_lsu.sv
// Bench for riscv_dmem_lsu: directed and random requests checked against a byte-array reference
// model with a queue of expected responses, each due a fixed number of cycles after acceptance.
module tb_riscv_dmem_lsu;

    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 256;
    localparam int READ_LAT = 3;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        req_ready, rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_rdata;

    riscv_dmem_lsu #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [DEPTH*4];
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         since_rel = 0;
    bit         in_reset = 1'b1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Reference model: memory as a flat byte array, access described by size and signedness
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        int unsigned a;
        int          size;
        bit          uns, ill, oob;
        logic [31:0] val;
        size = 0; uns = 0; ill = 0; rd = 32'b0;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; end
            3'd5: begin size = 2; uns = 1; end
            default: ill = 1;
        endcase
        if (we && (f3 == 3'd4 || f3 == 3'd5)) ill = 1;
`ifdef RISC_DMEM_BOUNDS_CHECK_EN
        oob = (addr >= DEPTH * 4);
`else
        oob = 0;
`endif
        a   = addr % (DEPTH * 4);
        err = ill || oob || (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[a + i] = wdata[8*i +: 8];
            end else begin
                val = 32'b0;
                for (int i = 0; i < size; i++) val = val | (32'(ref_mem[a + i]) << (8 * i));
                if (!uns && size < 4 && val[8*size-1]) val = val | (32'hFFFFFFFF << (8 * size));
                rd = val;
            end
        end
    endtask

    task automatic step_check();
        bit          rdy, ev;
        logic [31:0] er;
        logic        ee;
        rdy = !in_reset && since_rel >= DEPTH;
        check_output("req_ready", req_ready, rdy);
        check_output("init_done", init_done, rdy);
        ev = (exp_q.size() > 0) && (exp_q[0].due == cycle);
        er = 32'b0;
        ee = 1'b0;
        if (ev) begin
            er = exp_q[0].rdata;
            ee = exp_q[0].err;
            exp_q.delete(0);
        end
        check_output("rsp_valid", rsp_valid, ev);
        check_output("rsp_rdata", rsp_rdata, er);
        check_output("rsp_err", rsp_err, ee);
    endtask

    task automatic apply_stimulus(input logic valid, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit lit_en, input logic [31:0] lit);
        bit          ready_now;
        logic [31:0] rd;
        logic        err;
        ready_now  = !in_reset && since_rel >= DEPTH;
        req_valid  = valid;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        cycle++;
        if (valid && ready_now) begin
            model_req(we, f3, addr, wdata, rd, err);
            if (lit_en) rd = lit;
            exp_q.push_back('{cycle + READ_LAT - 1, rd, err});
        end
        if (!in_reset) since_rel++;
        #1;
        req_valid = 1'b0;
        step_check();
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        apply_stimulus(1'b1, 1'b1, f3, addr, wdata, 1'b0, 32'b0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr);
        apply_stimulus(1'b1, 1'b0, f3, addr, 32'b0, 1'b0, 32'b0);
    endtask

    task automatic ld_lit(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] lit);
        apply_stimulus(1'b1, 1'b0, f3, addr, 32'b0, 1'b1, lit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 3'd0, 32'b0, 32'b0, 1'b0, 32'b0);
    endtask

    // Reset drops mid-cycle; in-flight responses are discarded and the zero-fill clears memory
    task automatic do_reset();
        #2;
        areset   = 1'b0;
        in_reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
        #1;
        check_output("rst_rsp_valid", rsp_valid, 1'b0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'b0);
        check_output("rst_rsp_err", rsp_err, 1'b0);
        check_output("rst_req_ready", req_ready, 1'b0);
        check_output("rst_init_done", init_done, 1'b0);
        repeat (2) begin
            @(posedge clk);
            cycle++;
        end
        #1;
        areset    = 1'b1;
        since_rel = 0;
        in_reset  = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b1, 1'b0, 3'd2, 32'(4 * (i % 8)), 32'b0, 1'b0, 32'b0);
    endtask

    initial begin
        logic [31:0] addr;
        do_reset();
        wait_init();

        $display("[TB] write then reset: word must be cleared by zero-fill");
        st(3'd2, 32'h10, 32'h12345678);
        ld(3'd2, 32'h10);
        idle(READ_LAT);
        do_reset();
        wait_init();
        ld_lit(3'd2, 32'h10, 32'h00000000);

        $display("[TB] sub-word loads with sign and zero extension");
        st(3'd2, 32'h20, 32'h80FF7F01);
        ld_lit(3'd0, 32'h20, 32'h00000001);
        ld_lit(3'd0, 32'h21, 32'h0000007F);
        ld_lit(3'd0, 32'h22, 32'hFFFFFFFF);
        ld_lit(3'd4, 32'h22, 32'h000000FF);
        ld_lit(3'd1, 32'h22, 32'hFFFF80FF);
        ld_lit(3'd5, 32'h22, 32'h000080FF);

        $display("[TB] byte and halfword stores merge into a word");
        st(3'd2, 32'h40, 32'h11223344);
        st(3'd0, 32'h41, 32'h000000AA);
        st(3'd1, 32'h42, 32'h0000BEEF);
        ld_lit(3'd2, 32'h40, 32'hBEEFAA44);

        $display("[TB] misaligned, illegal and out-of-range requests");
        ld(3'd2, 32'h42);
        st(3'd1, 32'h43, 32'h00005555);
        st(3'd3, 32'h40, 32'hDEADBEEF);
        st(3'd4, 32'h40, 32'hDEADBEEF);
        ld(3'd7, 32'h40);
        ld_lit(3'd2, 32'h40, 32'hBEEFAA44);
        ld(3'd2, 32'h400);

        $display("[TB] store-to-load forwarding and back-to-back loads");
        st(3'd2, 32'h8, 32'hCAFEF00D);
        ld_lit(3'd2, 32'h8, 32'hCAFEF00D);
        for (int i = 0; i < 8; i++) ld(3'd2, 32'(4 * i));
        idle(READ_LAT);

        $display("[TB] reset with loads in flight");
        ld(3'd2, 32'h20);
        ld(3'd2, 32'h40);
        do_reset();
        wait_init();
        ld_lit(3'd2, 32'h20, 32'h0);
        ld_lit(3'd2, 32'h40, 32'h0);
        ld_lit(3'd2, 32'h8, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            addr = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) addr = addr | ($urandom << 10);
            apply_stimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)), addr, $urandom, 1'b0, 32'b0);
        end
        idle(READ_LAT + 1);
        check_output("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
